tank_sensor_conditioner: RTL and testbench

Upstream stage of the tank valve/alarm logic. It takes the raw float-switch contacts (high, mid, low) from the irrigation tank and synchronises and debounces each one. It checks that the three levels are physically consistent and drives clean h/m/l levels into the valve/alarm stage, plus a level code, a valid flag and a sensor-fault flag. Outputs are forced to safe combinations while not valid or while in fault.

---
 rtl/tank_sensor_conditioner_pkg.sv | 47 ++++
 rtl/tank_sensor_conditioner_if.sv | 23 ++
 rtl/tank_sensor_conditioner_debounce.sv | 42 ++++
 rtl/tank_sensor_conditioner.sv | 119 +++++++++++
 tb/tb_tank_sensor_conditioner.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tank_sensor_conditioner_pkg.sv
// Shared types and constants for the tank float-switch conditioner.
// Level codes, FSM states, sensor bit positions and safe output patterns.
package tank_pkg;

  localparam logic [1:0] LVL_EMPTY = 2'b00;
  localparam logic [1:0] LVL_LOW   = 2'b01;
  localparam logic [1:0] LVL_MID   = 2'b10;
  localparam logic [1:0] LVL_FULL  = 2'b11;

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    RUN     = 3'd1,
    SUSPECT = 3'd2,
    FAULT   = 3'd3,
    RECOVER = 3'd4
  } state_e;

  localparam int H_IDX = 2;
  localparam int M_IDX = 1;
  localparam int L_IDX = 0;

  localparam logic [2:0] SAFE_INIT  = 3'b111;
  localparam logic [2:0] SAFE_FAULT = 3'b100;

  function automatic logic is_consistent(input logic [2:0] s);
    logic ok;
    ok = 1'b0;
    case (s)
      3'b000, 3'b001, 3'b011, 3'b111: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [1:0] level_of(input logic [2:0] s);
    logic [1:0] lv;
    lv = LVL_EMPTY;
    case (s)
      3'b001:  lv = LVL_LOW;
      3'b011:  lv = LVL_MID;
      3'b111:  lv = LVL_FULL;
      default: lv = LVL_EMPTY;
    endcase
    return lv;
  endfunction

endpackage

// File: rtl/tank_sensor_conditioner_if.sv
// Sensor-side bundle: raw contacts in, conditioned levels and flags out.
// slave is the conditioner side, master is the driver/observer side.
interface tank_sensor_conditioner_if;
  logic       h_raw;
  logic       m_raw;
  logic       l_raw;
  logic       h;
  logic       m;
  logic       l;
  logic [1:0] level;
  logic       valid;
  logic       fault;

  modport master (
    output h_raw, m_raw, l_raw,
    input  h, m, l, level, valid, fault
  );

  modport slave (
    input  h_raw, m_raw, l_raw,
    output h, m, l, level, valid, fault
  );
endinterface

// File: rtl/tank_sensor_conditioner_debounce.sv
// Single-contact two-flop synchroniser followed by a persistence debouncer.
// filt_o flips only after the synced value differs for DEB_CYCLES edges.
module sensor_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic filt_o
);

  localparam logic [3:0] CNT_TOP = 4'(DEB_CYCLES - 1);

  logic       sync1_q;
  logic       sync2_q;
  logic       filt_q;
  logic [3:0] cnt_q;

  // sync chain plus persistence counter; toggle on the last differing edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      if (sync2_q == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_TOP) begin
        filt_q <= ~filt_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/tank_sensor_conditioner.sv
// Tank float-switch conditioner: debounce, consistency check, safe outputs.
// Define TANK_FAULT_LATCH_EN to make a confirmed fault sticky until rst.
module tank_sensor_conditioner
  import tank_pkg::*;
#(
  parameter int DEB_CYCLES   = 4,
  parameter int FAULT_CYCLES = 8
) (
  input logic                       clk,
  input logic                       rst,
  tank_sensor_conditioner_if.slave  bus
);

  localparam logic [4:0] SU_MAX = 5'(DEB_CYCLES + 3);
  localparam logic [7:0] FC_TOP = 8'(FAULT_CYCLES - 1);

  logic [2:0] raw;
  logic [2:0] filt;
  logic       cons;
  logic       valid;

  logic [4:0] su_q;
  logic [4:0] su_d;
  state_e     state_q;
  logic [7:0] fcnt_q;
  logic [1:0] level_q;
  logic       fault_q;
  logic [2:0] outs;

  assign raw[H_IDX] = bus.h_raw;
  assign raw[M_IDX] = bus.m_raw;
  assign raw[L_IDX] = bus.l_raw;

  for (genvar i = 0; i < 3; i++) begin : g_deb
    sensor_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (raw[i]),
      .filt_o (filt[i])
    );
  end

  assign cons  = is_consistent(filt);
  assign su_d  = (su_q == SU_MAX) ? su_q : su_q + 5'd1;
  assign valid = (su_q == SU_MAX);

  // start-up settle counter, saturating
  always_ff @(posedge clk) begin
    if (rst) su_q <= '0;
    else     su_q <= su_d;
  end

  // level supervisor: state, fault counter, level and fault flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      fcnt_q  <= '0;
      level_q <= LVL_EMPTY;
      fault_q <= 1'b0;
    end else begin
      fault_q <= (state_q == FAULT) ||
                 (state_q == RECOVER);
      unique case (state_q)
        INIT: begin
          if (valid) state_q <= RUN;
        end
        RUN: begin
          if (!cons) begin
            fcnt_q  <= '0;
            state_q <= SUSPECT;
          end else begin
            level_q <= level_of(filt);
          end
        end
        SUSPECT: begin
          if (cons)                  state_q <= RUN;
          else if (fcnt_q == FC_TOP) state_q <= FAULT;
          else                       fcnt_q  <= fcnt_q + 8'd1;
        end
        FAULT: begin
`ifdef TANK_FAULT_LATCH_EN
          state_q <= FAULT;
`else
          if (cons) begin
            fcnt_q  <= '0;
            state_q <= RECOVER;
          end
`endif
        end
        RECOVER: begin
          if (!cons)                 state_q <= FAULT;
          else if (fcnt_q == FC_TOP) state_q <= RUN;
          else                       fcnt_q  <= fcnt_q + 8'd1;
        end
        default: state_q <= INIT;
      endcase
    end
  end

  // output select driven only by registered state and filtered bits
  always_comb begin
    outs = SAFE_INIT;
    unique case (state_q)
      RUN, SUSPECT:   outs = filt;
      FAULT, RECOVER: outs = SAFE_FAULT;
      default:        outs = SAFE_INIT;
    endcase
  end

  assign bus.h     = outs[H_IDX];
  assign bus.m     = outs[M_IDX];
  assign bus.l     = outs[L_IDX];
  assign bus.level = level_q;
  assign bus.valid = valid;
  assign bus.fault = fault_q;

endmodule

// File: tb/tb_tank_sensor_conditioner.sv
// Bench for tank_sensor_conditioner: directed scenarios plus random run.
// Random run is compared against a run-length behavioural model.
module tb_tank_sensor_conditioner;

  localparam int DEB = 4;
  localparam int FC  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tank_sensor_conditioner_if bus();

  tank_sensor_conditioner #(
    .DEB_CYCLES   (DEB),
    .FAULT_CYCLES (FC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // behavioural model state
  logic [2:0] m_s1, m_s2, m_filt;
  int         m_run [3];
  int         m_su;
  bit         m_running;
  bit         m_fault_mode;
  int         m_bad, m_good;
  logic [1:0] m_level;
  logic       m_fault_o;

  function automatic bit ok_combo(input logic [2:0] s);
    return (s == 3'd0) || (s == 3'd1) ||
           (s == 3'd3) || (s == 3'd7);
  endfunction

  task automatic model_edge(input logic r,
                            input logic [2:0] raw);
    bit c;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_filt = 0;
      for (int b = 0; b < 3; b++) m_run[b] = 0;
      m_su = 0; m_running = 0; m_fault_mode = 0;
      m_bad = 0; m_good = 0;
      m_level = 0; m_fault_o = 0;
      return;
    end
    c = ok_combo(m_filt);
    if (m_running && !m_fault_mode && m_bad == 0 && c)
      m_level = 2'($countones(m_filt));
    m_fault_o = m_fault_mode;
    if (!m_running) begin
      if (m_su == DEB + 3) m_running = 1;
    end else if (!m_fault_mode) begin
      m_bad = c ? 0 : m_bad + 1;
      if (m_bad == FC + 1) begin
        m_fault_mode = 1; m_bad = 0; m_good = 0;
      end
    end else begin
      m_good = c ? m_good + 1 : 0;
`ifndef TANK_FAULT_LATCH_EN
      if (m_good == FC + 1) begin
        m_fault_mode = 0; m_good = 0; m_bad = 0;
      end
`endif
    end
    if (m_su < DEB + 3) m_su++;
    for (int b = 0; b < 3; b++) begin
      if (m_s2[b] != m_filt[b]) begin
        m_run[b]++;
        if (m_run[b] == DEB) begin
          m_filt[b] = ~m_filt[b];
          m_run[b] = 0;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  // raw is {h,m,l}; outputs are read 1 time unit after the edge
  task automatic tick(input logic r, input logic [2:0] raw);
    rst = r;
    {bus.h_raw, bus.m_raw, bus.l_raw} = raw;
    @(posedge clk);
    model_edge(r, raw);
    #1;
  endtask

  function automatic logic [2:0] hml();
    return {bus.h, bus.m, bus.l};
  endfunction

  task automatic test_reset();
    repeat (3) tick(1'b1, 3'b111);
    n_chk++;
    if (hml() !== 3'b111) begin
      n_fail++; $display("FAIL reset_hml got %b want 111", hml());
    end
    n_chk++;
    if (bus.valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got %b want 0", bus.valid);
    end
    n_chk++;
    if (bus.fault !== 1'b0) begin
      n_fail++; $display("FAIL reset_fault got %b want 0", bus.fault);
    end
    n_chk++;
    if (bus.level !== 2'b00) begin
      n_fail++; $display("FAIL reset_level got %b want 00", bus.level);
    end
  endtask

  task automatic test_startup();
    for (int k = 1; k <= 7; k++) begin
      tick(1'b0, 3'b111);
      n_chk++;
      if (hml() !== 3'b111) begin
        n_fail++; $display("FAIL start_hml e%0d got %b want 111", k, hml());
      end
      n_chk++;
      if (bus.valid !== (k == 7)) begin
        n_fail++;
        $display("FAIL start_valid e%0d got %b want %b", k, bus.valid, k == 7);
      end
    end
    tick(1'b0, 3'b111);
    tick(1'b0, 3'b111);
    n_chk++;
    if (bus.level !== 2'b11) begin
      n_fail++; $display("FAIL start_level got %b want 11", bus.level);
    end
  endtask

  task automatic test_glitch();
    bit seen_h = 0;
    repeat (20) tick(1'b0, 3'b011);
    n_chk++;
    if (bus.level !== 2'b10) begin
      n_fail++; $display("FAIL glitch_pre_level got %b want 10", bus.level);
    end
    repeat (3) begin
      tick(1'b0, 3'b111);
      if (bus.h) seen_h = 1;
    end
    repeat (15) begin
      tick(1'b0, 3'b011);
      if (bus.h) seen_h = 1;
    end
    n_chk++;
    if (seen_h) begin
      n_fail++; $display("FAIL glitch_h got 1 want 0");
    end
    n_chk++;
    if (bus.level !== 2'b10 || hml() !== 3'b011) begin
      n_fail++;
      $display("FAIL glitch_hold got lvl=%b hml=%b want 10/011", bus.level, hml());
    end
  endtask

  task automatic test_fill();
    repeat (20) tick(1'b0, 3'b001);
    n_chk++;
    if (bus.level !== 2'b01) begin
      n_fail++; $display("FAIL fill_pre_level got %b want 01", bus.level);
    end
    for (int k = 1; k <= 7; k++) begin
      tick(1'b0, 3'b011);
      if (k == 5) begin
        n_chk++;
        if (bus.m !== 1'b0) begin
          n_fail++; $display("FAIL fill_m_early got %b want 0", bus.m);
        end
      end
      if (k == 6) begin
        n_chk++;
        if (bus.m !== 1'b1 || bus.level !== 2'b01) begin
          n_fail++;
          $display("FAIL fill_m_e6 got m=%b lvl=%b want 1/01", bus.m, bus.level);
        end
      end
      if (k == 7) begin
        n_chk++;
        if (bus.level !== 2'b10) begin
          n_fail++; $display("FAIL fill_level_e7 got %b want 10", bus.level);
        end
      end
    end
  endtask

  task automatic test_fault();
    int e_out = 0;
    int e_flt = 0;
    int e_clr = 0;
    logic [2:0] hml14 = 3'b000;
    for (int k = 1; k <= 40; k++) begin
      tick(1'b0, 3'b101);
      if (e_out == 0 && hml() == 3'b100) e_out = k;
      if (e_flt == 0 && bus.fault) e_flt = k;
    end
    n_chk++;
    if (e_out != 15) begin
      n_fail++; $display("FAIL fault_out_edge got %0d want 15", e_out);
    end
    n_chk++;
    if (e_flt != 16) begin
      n_fail++; $display("FAIL fault_flag_edge got %0d want 16", e_flt);
    end
    for (int k = 1; k <= 40; k++) begin
      tick(1'b0, 3'b111);
      if (k == 14) hml14 = hml();
      if (e_clr == 0 && !bus.fault) e_clr = k;
    end
    n_chk++;
    if (hml14 !== 3'b100) begin
      n_fail++; $display("FAIL fault_recover_hold got %b want 100", hml14);
    end
`ifdef TANK_FAULT_LATCH_EN
    n_chk++;
    if (e_clr != 0 || hml() !== 3'b100) begin
      n_fail++;
      $display("FAIL fault_latch got clr=%0d hml=%b want 0/100", e_clr, hml());
    end
`else
    n_chk++;
    if (e_clr != 16) begin
      n_fail++; $display("FAIL fault_clear_edge got %0d want 16", e_clr);
    end
    n_chk++;
    if (hml() !== 3'b111 || bus.level !== 2'b11) begin
      n_fail++;
      $display("FAIL fault_after got hml=%b lvl=%b want 111/11", hml(), bus.level);
    end
`endif
  endtask

  task automatic test_reset_mid_fault();
    repeat (20) tick(1'b0, 3'b101);
    n_chk++;
    if (bus.fault !== 1'b1) begin
      n_fail++; $display("FAIL rmf_pre_fault got %b want 1", bus.fault);
    end
    tick(1'b1, 3'b101);
    n_chk++;
    if (bus.fault !== 1'b0 || bus.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rmf_flags got f=%b v=%b want 0/0", bus.fault, bus.valid);
    end
    n_chk++;
    if (hml() !== 3'b111 || bus.level !== 2'b00) begin
      n_fail++;
      $display("FAIL rmf_out got hml=%b lvl=%b want 111/00", hml(), bus.level);
    end
    repeat (12) tick(1'b0, 3'b111);
    n_chk++;
    if (bus.level !== 2'b11 || bus.valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rmf_restart got lvl=%b v=%b want 11/1", bus.level, bus.valid);
    end
  endtask

  task automatic test_suspect_abort();
    bit seen_bad = 0;
    bit seen_pass = 0;
    repeat (5) begin
      tick(1'b0, 3'b110);
      if (bus.fault || hml() == 3'b100) seen_bad = 1;
      if (hml() == 3'b110) seen_pass = 1;
    end
    repeat (20) begin
      tick(1'b0, 3'b111);
      if (bus.fault || hml() == 3'b100) seen_bad = 1;
      if (hml() == 3'b110) seen_pass = 1;
    end
    n_chk++;
    if (seen_bad) begin
      n_fail++; $display("FAIL abort_fault got 1 want 0");
    end
    n_chk++;
    if (!seen_pass) begin
      n_fail++; $display("FAIL abort_pass got 0 want 1");
    end
    n_chk++;
    if (bus.level !== 2'b11 || hml() !== 3'b111) begin
      n_fail++;
      $display("FAIL abort_end got lvl=%b hml=%b want 11/111", bus.level, hml());
    end
  endtask

  task automatic test_random();
    logic [2:0] tab [4];
    logic [2:0] c;
    logic [2:0] e_hml;
    int len;
    int cyc = 0;
    tab[0] = 3'b000; tab[1] = 3'b001;
    tab[2] = 3'b011; tab[3] = 3'b111;
    while (cyc < 600) begin
      if ($urandom_range(0, 4) != 0) c = tab[$urandom_range(0, 3)];
      else                           c = 3'($urandom);
      len = $urandom_range(1, 14);
      for (int k = 0; k < len; k++) begin
        tick((k == 0) && ($urandom_range(0, 39) == 0), c);
        cyc++;
        e_hml = !m_running ? 3'b111 :
                (m_fault_mode ? 3'b100 : m_filt);
        n_chk++;
        if (hml() !== e_hml) begin
          n_fail++;
          $display("FAIL rand_hml c%0d got %b want %b", cyc, hml(), e_hml);
        end
        n_chk++;
        if (bus.level !== m_level) begin
          n_fail++;
          $display("FAIL rand_level c%0d got %b want %b", cyc, bus.level, m_level);
        end
        n_chk++;
        if (bus.valid !== (m_su == DEB + 3)) begin
          n_fail++;
          $display("FAIL rand_valid c%0d got %b want %b", cyc, bus.valid,
                   m_su == DEB + 3);
        end
        n_chk++;
        if (bus.fault !== m_fault_o) begin
          n_fail++;
          $display("FAIL rand_fault c%0d got %b want %b", cyc, bus.fault, m_fault_o);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_glitch();
    test_fill();
    test_fault();
    test_reset_mid_fault();
    test_suspect_abort();
    repeat (2) tick(1'b1, 3'b000);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
